// File: rtl/p2s_bit_feeder.sv
// Parallel-to-serial bit feeder. It takes DATA_W-bit words over a valid/ready handshake
// and sends them out one bit at a time. Each bit is held for BIT_DIV clocks. Back-to-back
// words are sent with no idle gap because the next word is reloaded on the last clock of
// the current word.
module p2s_bit_feeder #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_DIV    = 1,
    parameter int unsigned MSB_FIRST  = 1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic              data_out_o,
    output logic              bit_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned BCW = $clog2(DATA_W);
    localparam int unsigned DCW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [BCW-1:0] BitLast = BCW'(DATA_W - 1);
    localparam logic [DCW-1:0] DivLast = DCW'(BIT_DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;

    logic last_div;
    logic last_bit;
    logic word_end;
    logic accept;
    logic head_bit;

    // Decode: terminal counts, handshake and serial head bit from registered state only.
    always_comb begin
        last_div    = (div_cnt_q == DivLast);
        last_bit    = (bit_cnt_q == BitLast);
        word_end    = (state_q == StShift) && last_div && last_bit;
        // Ready never looks at din_valid_i, so there is no valid->ready loop.
        din_ready_o = (state_q == StIdle) || word_end;
        accept      = din_valid_i && din_ready_o;
        head_bit    = (MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0];
        busy_o      = (state_q == StShift);
        data_out_o  = (state_q == StShift) ? head_bit : IDLE_LEVEL;
        bit_valid_o = (state_q == StShift) && (div_cnt_q == '0);
        done_o      = word_end;
    end

    // Next state: load on accept, hold each bit BIT_DIV clocks, then advance or finish.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StShift;
                    sreg_d    = din_i;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            StShift: begin
                if (!last_div) begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end else if (!last_bit) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (MSB_FIRST != 0) begin
                        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
                    end
                end else if (accept) begin
                    // Reload in place so the next word's first bit follows with no gap.
                    sreg_d    = din_i;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; synchronous reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_p2s_bit_feeder.sv
// Bench for p2s_bit_feeder: three instances (MSB-first div 1, MSB-first div 3,
// LSB-first div 1) driven by a vector table plus hand-written multi-cycle sequences.
module tb_p2s_bit_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] din   [3];
    logic       valid [3];
    logic       rdy   [3];
    logic       dout  [3];
    logic       bvld  [3];
    logic       busy  [3];
    logic       done  [3];

    int total;
    int bad;

    p2s_bit_feeder #(.DATA_W(8), .BIT_DIV(1), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_i      (din[0]),
        .din_valid_i(valid[0]),
        .din_ready_o(rdy[0]),
        .data_out_o (dout[0]),
        .bit_valid_o(bvld[0]),
        .busy_o     (busy[0]),
        .done_o     (done[0])
    );

    p2s_bit_feeder #(.DATA_W(8), .BIT_DIV(3), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_i      (din[1]),
        .din_valid_i(valid[1]),
        .din_ready_o(rdy[1]),
        .data_out_o (dout[1]),
        .bit_valid_o(bvld[1]),
        .busy_o     (busy[1]),
        .done_o     (done[1])
    );

    p2s_bit_feeder #(.DATA_W(8), .BIT_DIV(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_c (
        .clk        (clk),
        .rst        (rst),
        .din_i      (din[2]),
        .din_valid_i(valid[2]),
        .din_ready_o(rdy[2]),
        .data_out_o (dout[2]),
        .bit_valid_o(bvld[2]),
        .busy_o     (busy[2]),
        .done_o     (done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word, instance, hold length, and the expected serial order (seq[7] goes out first).
    typedef struct {
        int unsigned dut;
        int unsigned div;
        logic [7:0]  word;
        logic [7:0]  seq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{dut: 0, div: 1, word: 8'h90, seq: 8'b1001_0000};
        vecs[1] = '{dut: 0, div: 1, word: 8'h5A, seq: 8'b0101_1010};
        vecs[2] = '{dut: 1, div: 3, word: 8'hC3, seq: 8'b1100_0011};
        vecs[3] = '{dut: 1, div: 3, word: 8'h80, seq: 8'b1000_0000};
        vecs[4] = '{dut: 2, div: 1, word: 8'h12, seq: 8'b0100_1000};
        vecs[5] = '{dut: 2, div: 1, word: 8'h01, seq: 8'b1000_0000};

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din[d]   = 8'h00;
            valid[d] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;

        // Reset state on every instance.
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ready[%0d]", d), 32'(rdy[d]), 32'd1);
            check($sformatf("reset_outs[%0d]", d),
                  32'({dout[d], bvld[d], busy[d], done[d]}), 32'h0);
        end

        // Idle with valid low: nothing moves for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            step();
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("idle_c%0d[%0d]", c, d),
                      32'({dout[d], bvld[d], busy[d], done[d], rdy[d]}), 32'h1);
            end
        end
        step();

        // Table: one-cycle valid, din scrambled while busy, full bit/timing check.
        for (int v = 0; v < 6; v++) begin
            int unsigned d;
            int unsigned n;
            d = vecs[v].dut;
            n = 8 * vecs[v].div;
            din[d]   = vecs[v].word;
            valid[d] = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_ready_idle", v), 32'(rdy[d]), 32'd1);
            step();
            valid[d] = 1'b0;
            din[d]   = ~vecs[v].word;
            for (int k = 0; k < int'(n); k++) begin
                logic exp_bit;
                logic exp_end;
                logic [7:0] s;
                s = vecs[v].seq;
                exp_bit = s[7 - k / int'(vecs[v].div)];
                exp_end = (k == int'(n) - 1);
                @(negedge clk);
                check($sformatf("v%0d_c%0d_data", v, k), 32'(dout[d]), 32'(exp_bit));
                check($sformatf("v%0d_c%0d_bvld", v, k), 32'(bvld[d]),
                      32'((k % int'(vecs[v].div)) == 0));
                check($sformatf("v%0d_c%0d_busy", v, k), 32'(busy[d]), 32'd1);
                check($sformatf("v%0d_c%0d_done", v, k), 32'(done[d]), 32'(exp_end));
                check($sformatf("v%0d_c%0d_rdy", v, k), 32'(rdy[d]), 32'(exp_end));
                din[d] = $urandom_range(0, 255);
                step();
            end
            @(negedge clk);
            check($sformatf("v%0d_after", v),
                  32'({dout[d], bvld[d], busy[d], done[d], rdy[d]}), 32'h1);
            step();
        end

        // Back-to-back words with valid held high: 16 contiguous bits.
        begin
            logic [15:0] stream;
            stream   = 16'hA53C;
            din[0]   = 8'hA5;
            valid[0] = 1'b1;
            @(negedge clk);
            check("b2b_ready_t0", 32'(rdy[0]), 32'd1);
            step();
            din[0] = 8'h3C;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                check($sformatf("b2b_c%0d_data", k), 32'(dout[0]), 32'(stream[15 - k]));
                check($sformatf("b2b_c%0d_busy", k), 32'(busy[0]), 32'd1);
                check($sformatf("b2b_c%0d_rdy", k), 32'(rdy[0]), 32'(k == 7 || k == 15));
                check($sformatf("b2b_c%0d_done", k), 32'(done[0]), 32'(k == 7 || k == 15));
                step();
                if (k == 7) begin
                    valid[0] = 1'b0;
                    din[0]   = 8'hFF;
                end
            end
            @(negedge clk);
            check("b2b_after_busy", 32'(busy[0]), 32'd0);
            step();
        end

        // Reset after three bits of 8'hFF: word dropped, no done pulse.
        din[0]   = 8'hFF;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_c%0d_data", k), 32'(dout[0]), 32'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_after_c%0d", c),
                  32'({dout[0], busy[0], done[0], rdy[0]}), 32'h1);
            step();
        end

        // Reset together with valid: reset wins, nothing is accepted.
        din[0]   = 8'hFF;
        valid[0] = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        valid[0] = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_busy", 32'(busy[0]), 32'd0);
        check("rst_vs_valid_data", 32'(dout[0]), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
